cc_shift_ring_pipe: RTL

Parametrised, registered ring rotator for the round-robin arbiter datapath. Rotates a WIDTH-bit request/grant vector left or right by an external amount or by an internal rotating priority pointer. Output is held in a single pipeline register with a valid/ready handshake. Used to normalise requests to the current priority position and to de-normalise grants back.

---
 rtl/cc_shift_ring_pipe.sv | 118 +++++++++++
 1 files changed

// File: rtl/cc_shift_ring_pipe.sv
// Registered ring rotator for the round-robin arbiter datapath: rotates a request/grant
// vector by an external amount or by an internal priority pointer, behind a valid/ready stage.
module cc_shift_ring_pipe #(
    parameter  int WIDTH = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In_Bus,
    input  logic [SHW-1:0]   Shift,
    input  logic             Dir,
    input  logic             Use_Ptr,
    input  logic             Ptr_Load,
    input  logic [SHW-1:0]   Ptr_Load_Val,
    input  logic             Ptr_Adv,
    output logic [SHW-1:0]   Ptr,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Bus,
    output logic [SHW-1:0]   Out_Amt
);

    // Non-power-of-two widths leave encodable values above WIDTH-1; fold them back into range.
    function automatic logic [SHW-1:0] wrap_amt(input logic [SHW-1:0] v);
        return SHW'(32'(v) % 32'(WIDTH));
    endfunction

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v, input logic [SHW-1:0] k);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[(i + WIDTH - int'(k)) % WIDTH];
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v, input logic [SHW-1:0] k);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[(i + int'(k)) % WIDTH];
        end
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_bus_q, out_bus_d;
    logic [SHW-1:0]   out_amt_q, out_amt_d;
    logic [SHW-1:0]   ptr_q, ptr_d;
    logic             in_ready_s;
    logic             accept_s;
    logic [SHW-1:0]   amt_s;
    logic [WIDTH-1:0] rot_s;

    // Handshake, effective amount and rotated data for the current cycle.
    always_comb begin
        in_ready_s = !out_valid_q || Out_Ready;
        accept_s   = In_Valid && in_ready_s;
        amt_s      = wrap_amt(Use_Ptr ? ptr_q : Shift);
        if (Dir) begin
            rot_s = rot_right(In_Bus, amt_s);
        end else begin
            rot_s = rot_left(In_Bus, amt_s);
        end
    end

    // Output-stage next state: load on accept, drop valid on drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bus_d   = out_bus_q;
        out_amt_d   = out_amt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_bus_d   = rot_s;
            out_amt_d   = amt_s;
        end else if (Out_Ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pointer next state, independent of the handshake; load has priority over advance.
    always_comb begin
        ptr_d = ptr_q;
        if (Ptr_Load) begin
            ptr_d = wrap_amt(Ptr_Load_Val);
        end else if (Ptr_Adv) begin
            ptr_d = (ptr_q == SHW'(WIDTH - 1)) ? '0 : ptr_q + SHW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            out_bus_q   <= '0;
            out_amt_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_bus_q   <= out_bus_d;
            out_amt_q   <= out_amt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign In_Ready  = in_ready_s;
    assign Out_Valid = out_valid_q;
    assign Out_Bus   = out_bus_q;
    assign Out_Amt   = out_amt_q;
    assign Ptr       = ptr_q;

endmodule
